// File: rtl/flag_pkg.sv
// Shared encodings for the flag/branch unit: ALU funcs, branch conditions,
// flag bit positions and the redirect FSM state type.
package flag_pkg;

  localparam logic [2:0] FUNC_ADD = 3'b000;
  localparam logic [2:0] FUNC_SUB = 3'b001;
  localparam logic [2:0] FUNC_AND = 3'b010;
  localparam logic [2:0] FUNC_NOR = 3'b011;
  localparam logic [2:0] FUNC_SLL = 3'b100;
  localparam logic [2:0] FUNC_SRL = 3'b101;
  localparam logic [2:0] FUNC_SRA = 3'b110;
  localparam logic [2:0] FUNC_LHB = 3'b111;

  localparam logic [2:0] COND_NE  = 3'b000;
  localparam logic [2:0] COND_EQ  = 3'b001;
  localparam logic [2:0] COND_GT  = 3'b010;
  localparam logic [2:0] COND_LT  = 3'b011;
  localparam logic [2:0] COND_GE  = 3'b100;
  localparam logic [2:0] COND_LE  = 3'b101;
  localparam logic [2:0] COND_OV  = 3'b110;
  localparam logic [2:0] COND_UNC = 3'b111;

  localparam int FLG_Z = 2;
  localparam int FLG_V = 1;
  localparam int FLG_N = 0;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REDIR  = 2'd1,
    ST_SHADOW = 2'd2
  } state_t;

  // Which flag bits an ALU func is allowed to write.
  function automatic logic [2:0] flag_mask(input logic [2:0] func);
    logic [2:0] m;
    m = 3'b000;
    case (func)
      FUNC_ADD, FUNC_SUB: m = 3'b111;
      FUNC_LHB:           m = 3'b000;
      default:            m[FLG_Z] = 1'b1;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// Combinational branch condition evaluator over {Z,V,N}.
module cond_eval
  import flag_pkg::*;
(
  input  logic [2:0] flags,
  input  logic [2:0] cond,
  output logic       take
);

  logic z;
  logic v;
  logic n;

  assign z = flags[FLG_Z];
  assign v = flags[FLG_V];
  assign n = flags[FLG_N];

  always_comb begin
    take = 1'b0;
    case (cond)
      COND_NE:  take = ~z;
      COND_EQ:  take = z;
      COND_GT:  take = ~z & ~n;
      COND_LT:  take = n;
      COND_GE:  take = z | ~n;
      COND_LE:  take = n | z;
      COND_OV:  take = v;
      default:  take = 1'b1;
    endcase
  end

endmodule

// File: rtl/flag_branch_unit.sv
// Architectural flag register with EX->branch bypass, and a three-state
// redirect/flush sequencer that shields one wrong-path slot after each redirect.
module flag_branch_unit
  import flag_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COND_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              ex_valid,
  input  logic [2:0]        ex_func,
  input  logic              alu_zr,
  input  logic              alu_ov,
  input  logic              alu_msb,
  input  logic              br_valid,
  input  logic [COND_W-1:0] br_cond,
  input  logic [DATA_W-1:0] br_target,
  output logic [2:0]        flags_q,
  output logic              redirect,
  output logic [DATA_W-1:0] redirect_pc,
  output logic              flush
);

  state_t            state_reg;
  state_t            state_next;
  logic [2:0]        flags_reg;
  logic [2:0]        eff_flags;
  logic [2:0]        alu_flags;
  logic [2:0]        upd_mask;
  logic [DATA_W-1:0] pc_reg;
  logic [DATA_W-1:0] pc_next;
  logic              flush_kill;
  logic              upd;
  logic              take;

  assign flush_kill = (state_reg == ST_SHADOW);
  assign upd        = ex_valid & ~stall & ~flush_kill;
  assign upd_mask   = upd ? flag_mask(ex_func) : 3'b000;

  always_comb begin
    alu_flags        = 3'b000;
    alu_flags[FLG_Z] = alu_zr;
    alu_flags[FLG_V] = alu_ov;
    alu_flags[FLG_N] = alu_msb;
  end

  // Effective flags double as the register's next value and the branch bypass.
  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_flag_mux
      assign eff_flags[gi] = upd_mask[gi] ? alu_flags[gi] : flags_reg[gi];
    end
  endgenerate

  cond_eval u_cond_eval (
    .flags (eff_flags),
    .cond  (br_cond[2:0]),
    .take  (take)
  );

  always_comb begin
    state_next = state_reg;
    pc_next    = pc_reg;
    if (!stall) begin
      case (state_reg)
        ST_IDLE: begin
          if (br_valid && take) begin
            state_next = ST_REDIR;
            pc_next    = br_target;
          end
        end
        ST_REDIR:  state_next = ST_SHADOW;
        ST_SHADOW: state_next = ST_IDLE;
        default:   state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      flags_reg <= 3'b000;
      pc_reg    <= '0;
    end else begin
      state_reg <= state_next;
      flags_reg <= eff_flags;
      pc_reg    <= pc_next;
    end
  end

  assign flags_q     = flags_reg;
  assign redirect    = (state_reg == ST_REDIR);
  assign flush       = (state_reg == ST_REDIR);
  assign redirect_pc = pc_reg;

endmodule

// File: tb/tb_flag_branch_unit.sv
// Directed-vector bench: each vector pushes its hand-computed post-edge outputs
// into a scoreboard queue; a monitor pops and checks after every clock edge.
module tb_flag_branch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall = 1'b0;
  logic        ex_valid = 1'b0;
  logic [2:0]  ex_func = 3'b000;
  logic        alu_zr = 1'b0;
  logic        alu_ov = 1'b0;
  logic        alu_msb = 1'b0;
  logic        br_valid = 1'b0;
  logic [2:0]  br_cond = 3'b000;
  logic [15:0] br_target = 16'h0000;
  logic [2:0]  flags_q;
  logic        redirect;
  logic [15:0] redirect_pc;
  logic        flush;

  flag_branch_unit #(.DATA_W(16), .COND_W(3)) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .ex_valid    (ex_valid),
    .ex_func     (ex_func),
    .alu_zr      (alu_zr),
    .alu_ov      (alu_ov),
    .alu_msb     (alu_msb),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_target   (br_target),
    .flags_q     (flags_q),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .flush       (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          row;
    logic [2:0]  flags;
    logic        red;
    logic        chk_pc;
    logic [15:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad = 0;
  int   row_cnt = 0;

  task automatic chk(input string nm, input int row, input logic [15:0] act, input logic [15:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s row=%0d got=%h want=%h", nm, row, act, want);
    end
  endtask

  // Monitor: checks outputs produced by the previous edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      chk("flags_q", e.row, {13'd0, flags_q}, {13'd0, e.flags});
      chk("redirect", e.row, {15'd0, redirect}, {15'd0, e.red});
      chk("flush", e.row, {15'd0, flush}, {15'd0, e.red});
      if (e.chk_pc) chk("redirect_pc", e.row, redirect_pc, e.pc);
      $display("row %0d: flags=%b redirect=%b flush=%b pc=%h", e.row, flags_q, redirect, flush, redirect_pc);
    end
  end

  task automatic vec(input logic r, input logic s, input logic ev, input logic [2:0] f,
                     input logic zr, input logic ov, input logic msb,
                     input logic bv, input logic [2:0] c, input logic [15:0] tgt,
                     input logic [2:0] e_flags, input logic e_red, input logic e_chk, input logic [15:0] e_pc);
    exp_t e;
    @(negedge clk);
    rst = r; stall = s; ex_valid = ev; ex_func = f;
    alu_zr = zr; alu_ov = ov; alu_msb = msb;
    br_valid = bv; br_cond = c; br_target = tgt;
    e.row = row_cnt; e.flags = e_flags; e.red = e_red; e.chk_pc = e_chk | e_red; e.pc = e_pc;
    exp_q.push_back(e);
    row_cnt++;
  endtask

  initial begin
    // reset, then reset while in REDIR
    vec(1,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b000,0,1,16'h0000);
    vec(1,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b000,0,1,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 1,3'b111,16'h00AA, 3'b000,1,0,16'h00AA);
    vec(1,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b000,0,1,16'h0000);
    vec(1,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b000,0,1,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b000,0,0,16'h0000);
    // flag update masks
    vec(0,0, 1,3'b000,1,0,0, 0,3'b000,16'h0000, 3'b100,0,0,16'h0000);
    vec(0,0, 1,3'b010,0,1,1, 0,3'b000,16'h0000, 3'b000,0,0,16'h0000);
    vec(0,0, 1,3'b000,0,1,1, 0,3'b000,16'h0000, 3'b011,0,0,16'h0000);
    vec(0,0, 1,3'b011,1,0,0, 0,3'b000,16'h0000, 3'b111,0,0,16'h0000);
    vec(0,0, 1,3'b111,0,0,0, 0,3'b000,16'h0000, 3'b111,0,0,16'h0000);
    vec(0,0, 1,3'b001,0,0,0, 0,3'b000,16'h0000, 3'b000,0,0,16'h0000);
    vec(0,0, 1,3'b111,1,1,1, 0,3'b000,16'h0000, 3'b000,0,0,16'h0000);
    vec(0,0, 1,3'b100,1,1,1, 0,3'b000,16'h0000, 3'b100,0,0,16'h0000);
    vec(0,0, 1,3'b110,0,0,0, 0,3'b000,16'h0000, 3'b000,0,0,16'h0000);
    // bypass: SUB sets Z same cycle as EQ branch
    vec(0,0, 1,3'b001,1,0,0, 1,3'b001,16'h0040, 3'b100,1,0,16'h0040);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b100,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b100,0,0,16'h0000);
    // untaken NE and GT with Z=1
    vec(0,0, 0,3'b000,0,0,0, 1,3'b000,16'h0BAD, 3'b100,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b100,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 1,3'b010,16'h0BAD, 3'b100,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b100,0,0,16'h0000);
    // bypass on N: ADD msb=1 with LT branch
    vec(0,0, 1,3'b000,0,0,1, 1,3'b011,16'h0222, 3'b001,1,0,16'h0222);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,0,0,16'h0000);
    // shadow: branch in REDIR and SHADOW ignored, ADD in SHADOW suppressed
    vec(0,0, 0,3'b000,0,0,0, 1,3'b111,16'h1234, 3'b001,1,0,16'h1234);
    vec(0,0, 0,3'b000,0,0,0, 1,3'b111,16'h5555, 3'b001,0,0,16'h0000);
    vec(0,0, 1,3'b000,0,1,0, 1,3'b111,16'h6666, 3'b001,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,0,0,16'h0000);
    // stall held 3 cycles in REDIR
    vec(0,0, 0,3'b000,0,0,0, 1,3'b111,16'h0ABC, 3'b001,1,0,16'h0ABC);
    vec(0,1, 1,3'b000,1,1,1, 0,3'b000,16'h0000, 3'b001,1,0,16'h0ABC);
    vec(0,1, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,1,0,16'h0ABC);
    vec(0,1, 0,3'b000,0,0,0, 1,3'b111,16'h7777, 3'b001,1,0,16'h0ABC);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,0,0,16'h0000);
    // stalled branch in IDLE not captured; then LE taken on N
    vec(0,1, 0,3'b000,0,0,0, 1,3'b111,16'h0F0F, 3'b001,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 1,3'b101,16'h0101, 3'b001,1,0,16'h0101);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,0,0,16'h0000);
    vec(0,0, 0,3'b000,0,0,0, 0,3'b000,16'h0000, 3'b001,0,0,16'h0000);
    repeat (3) @(posedge clk);
    #2;
    chk("scoreboard_drain", row_cnt, exp_q.size(), 16'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
